frog_game_ctrl: RTL

- Game-logic stage directly upstream of the VGA renderer.
- Owns frog position (FrogX/FrogY) and three crocodile vertical positions (CrocY1..3), all driven into the renderer.
- Consumes the renderer's registered InFrog/InCroc pixel flags for collision detection.
- Runs the play/hit/win/game-over state machine, advancing once per video frame.

---
 rtl/frog_game_pkg.sv | 33 +++
 rtl/frog_game_ctrl_if.sv | 28 ++
 rtl/frog_game_ctrl_croc_mover.sv | 66 ++++++
 rtl/frog_game_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/frog_game_pkg.sv
// Shared definitions for the frog game controller: state encoding, playfield bounds
// and default crocodile limits.
package frog_game_pkg;

  typedef enum logic [1:0] {
    StPlay = 2'd0,
    StHit  = 2'd1,
    StWin  = 2'd2,
    StOver = 2'd3
  } game_state_e;

  // Croc direction in screen terms: down means Y increasing.
  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } croc_dir_e;

  // Frog playfield bounds (left/top edge of the sprite).
  localparam int unsigned FROG_X_MIN = 152;
  localparam int unsigned FROG_X_MAX = 743;
  localparam int unsigned FROG_Y_MIN = 40;
  localparam int unsigned FROG_Y_MAX = 471;

  localparam int unsigned SPRITE_SIZE = 32;

  // Default croc vertical limits and the middle croc's start position.
  localparam int unsigned CROC_Y_MIN_DEF = 32;
  localparam int unsigned CROC_Y_MAX_DEF = 403;
  localparam int unsigned CROC2_Y_START  = 200;

  localparam logic [1:0] LIVES_START = 2'd3;

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Signal bundle between the game controller and the VGA renderer / button front end.
// master: renderer side (drives sync, buttons, pixel flags); slave: game controller.
interface frog_game_ctrl_if;
  logic       vga_v_sync;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       InFrog;
  logic       InCroc;
  logic [9:0] FrogX;
  logic [9:0] FrogY;
  logic [8:0] CrocY1;
  logic [8:0] CrocY2;
  logic [8:0] CrocY3;
  logic [1:0] game_state;
  logic [1:0] lives;

  modport master (
    output vga_v_sync, btn_up, btn_down, btn_left, btn_right, InFrog, InCroc,
    input  FrogX, FrogY, CrocY1, CrocY2, CrocY3, game_state, lives
  );

  modport slave (
    input  vga_v_sync, btn_up, btn_down, btn_left, btn_right, InFrog, InCroc,
    output FrogX, FrogY, CrocY1, CrocY2, CrocY3, game_state, lives
  );
endinterface

// File: rtl/frog_game_ctrl_croc_mover.sv
// One crocodile's vertical position and direction. Bounces between YMin and YMax,
// saturating at the bound and reversing in the same tick.
module croc_mover
  import frog_game_pkg::*;
#(
  parameter int unsigned YReset   = 32,
  parameter croc_dir_e   DirReset = DirDown,
  parameter int unsigned YMin     = CROC_Y_MIN_DEF,
  parameter int unsigned YMax     = CROC_Y_MAX_DEF
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       enable_i,
  input  logic       restart_i,
  input  logic [2:0] speed_i,
  output logic [8:0] croc_y_o
);

  logic [8:0] y_q, y_d;
  croc_dir_e  dir_q, dir_d;
  logic [9:0] y_up_sum;
  logic [9:0] y_lo_lim;

  // Next position: restart wins over motion; arithmetic in 10 bits so nothing wraps.
  always_comb begin
    y_d      = y_q;
    dir_d    = dir_q;
    y_up_sum = {1'b0, y_q} + {7'd0, speed_i};
    y_lo_lim = 10'(YMin) + {7'd0, speed_i};
    if (tick_i && restart_i) begin
      y_d   = 9'(YReset);
      dir_d = DirReset;
    end else if (tick_i && enable_i) begin
      if (dir_q == DirDown) begin
        if (y_up_sum > 10'(YMax)) begin
          y_d   = 9'(YMax);
          dir_d = DirUp;
        end else begin
          y_d = y_up_sum[8:0];
        end
      end else begin
        if ({1'b0, y_q} < y_lo_lim) begin
          y_d   = 9'(YMin);
          dir_d = DirDown;
        end else begin
          y_d = y_q - {6'd0, speed_i};
        end
      end
    end
  end

  // Position/direction registers.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      y_q   <= 9'(YReset);
      dir_q <= DirReset;
    end else begin
      y_q   <= y_d;
      dir_q <= dir_d;
    end
  end

  assign croc_y_o = y_q;

endmodule

// File: rtl/frog_game_ctrl.sv
// Frog game logic: frog position, three crocs, collision latch and the
// play/hit/win/over state machine, all advancing once per frame (vsync rising edge).
// Optional build macro FROG_GAME_LEVEL_EN adds a difficulty level that speeds up crocs.
module frog_game_ctrl
  import frog_game_pkg::*;
#(
  parameter int unsigned FROG_X_START = 152,
  parameter int unsigned FROG_Y_START = 240,
  parameter int unsigned FROG_STEP    = 4,
  parameter int unsigned CROC_Y_MIN   = CROC_Y_MIN_DEF,
  parameter int unsigned CROC_Y_MAX   = CROC_Y_MAX_DEF,
  parameter int unsigned CROC_SPD1    = 1,
  parameter int unsigned CROC_SPD2    = 2,
  parameter int unsigned CROC_SPD3    = 3,
  parameter int unsigned WIN_X        = 700,
  parameter int unsigned HIT_FRAMES   = 60
) (
  input logic             dclk,
  input logic             rst,
  frog_game_ctrl_if.slave bus
);

  localparam int unsigned HitCntW = $clog2(HIT_FRAMES);

  localparam logic [10:0] XMin = 11'(FROG_X_MIN);
  localparam logic [10:0] XMax = 11'(FROG_X_MAX);
  localparam logic [10:0] YMin = 11'(FROG_Y_MIN);
  localparam logic [10:0] YMax = 11'(FROG_Y_MAX);
  localparam logic [10:0] Step = 11'(FROG_STEP);

  logic               vs_q;
  logic               tick;
  logic               collide;
  logic               any_btn;
  logic               hit_latch_q, hit_latch_d;
  game_state_e        state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [HitCntW-1:0] hit_cnt_q, hit_cnt_d;
  logic [9:0]         frog_x_q, frog_x_d;
  logic [9:0]         frog_y_q, frog_y_d;
  logic [10:0]        x_ext, y_ext, x_n, y_n;
  logic               croc_en;
  logic               croc_restart;
  logic [2:0]         spd1, spd2, spd3;

  assign tick    = bus.vga_v_sync & ~vs_q;
  assign collide = bus.InFrog & bus.InCroc;
  assign any_btn = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;

  // On the tick edge the FSM consumes the old latch, so reload with this cycle's collision.
  assign hit_latch_d = tick ? collide : (hit_latch_q | collide);

`ifdef FROG_GAME_LEVEL_EN
  logic [1:0] level_q, level_d;

  assign spd1 = 3'(CROC_SPD1) + {1'b0, level_q};
  assign spd2 = 3'(CROC_SPD2) + {1'b0, level_q};
  assign spd3 = 3'(CROC_SPD3) + {1'b0, level_q};
`else
  assign spd1 = 3'(CROC_SPD1);
  assign spd2 = 3'(CROC_SPD2);
  assign spd3 = 3'(CROC_SPD3);
`endif

  // Candidate frog position for this tick: one step, up > down > left > right, clamped.
  always_comb begin
    x_ext = {1'b0, frog_x_q};
    y_ext = {1'b0, frog_y_q};
    x_n   = x_ext;
    y_n   = y_ext;
    if (bus.btn_up) begin
      y_n = (y_ext < YMin + Step) ? YMin : y_ext - Step;
    end else if (bus.btn_down) begin
      y_n = (y_ext + Step > YMax) ? YMax : y_ext + Step;
    end else if (bus.btn_left) begin
      x_n = (x_ext < XMin + Step) ? XMin : x_ext - Step;
    end else if (bus.btn_right) begin
      x_n = (x_ext + Step > XMax) ? XMax : x_ext + Step;
    end
  end

  // Game FSM next state; everything only moves on the frame tick.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    hit_cnt_d    = hit_cnt_q;
    frog_x_d     = frog_x_q;
    frog_y_d     = frog_y_q;
    croc_en      = 1'b0;
    croc_restart = 1'b0;
`ifdef FROG_GAME_LEVEL_EN
    level_d      = level_q;
`endif
    if (tick) begin
      unique case (state_q)
        StPlay: begin
          croc_en = 1'b1;
          // Hit takes priority over movement and win.
          if (hit_latch_q) begin
            state_d   = StHit;
            lives_d   = lives_q - 2'd1;
            hit_cnt_d = '0;
          end else begin
            frog_x_d = x_n[9:0];
            frog_y_d = y_n[9:0];
            if (x_n >= 11'(WIN_X)) begin
              state_d = StWin;
            end
          end
        end
        StHit: begin
          if (hit_cnt_q == HitCntW'(HIT_FRAMES - 1)) begin
            if (lives_q == 2'd0) begin
              state_d = StOver;
            end else begin
              frog_x_d = 10'(FROG_X_START);
              frog_y_d = 10'(FROG_Y_START);
              state_d  = StPlay;
            end
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
        StWin, StOver: begin
          if (any_btn) begin
            croc_restart = 1'b1;
            frog_x_d     = 10'(FROG_X_START);
            frog_y_d     = 10'(FROG_Y_START);
            lives_d      = LIVES_START;
            state_d      = StPlay;
`ifdef FROG_GAME_LEVEL_EN
            if (state_q == StWin) begin
              level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
            end else begin
              level_d = 2'd0;
            end
`endif
          end
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b0;
      hit_latch_q <= 1'b0;
      state_q     <= StPlay;
      lives_q     <= LIVES_START;
      hit_cnt_q   <= '0;
      frog_x_q    <= 10'(FROG_X_START);
      frog_y_q    <= 10'(FROG_Y_START);
`ifdef FROG_GAME_LEVEL_EN
      level_q     <= 2'd0;
`endif
    end else begin
      vs_q        <= bus.vga_v_sync;
      hit_latch_q <= hit_latch_d;
      state_q     <= state_d;
      lives_q     <= lives_d;
      hit_cnt_q   <= hit_cnt_d;
      frog_x_q    <= frog_x_d;
      frog_y_q    <= frog_y_d;
`ifdef FROG_GAME_LEVEL_EN
      level_q     <= level_d;
`endif
    end
  end

  croc_mover #(
    .YReset  (CROC_Y_MIN),
    .DirReset(DirDown),
    .YMin    (CROC_Y_MIN),
    .YMax    (CROC_Y_MAX)
  ) u_croc1 (
    .dclk     (dclk),
    .rst      (rst),
    .tick_i   (tick),
    .enable_i (croc_en),
    .restart_i(croc_restart),
    .speed_i  (spd1),
    .croc_y_o (bus.CrocY1)
  );

  croc_mover #(
    .YReset  (CROC2_Y_START),
    .DirReset(DirUp),
    .YMin    (CROC_Y_MIN),
    .YMax    (CROC_Y_MAX)
  ) u_croc2 (
    .dclk     (dclk),
    .rst      (rst),
    .tick_i   (tick),
    .enable_i (croc_en),
    .restart_i(croc_restart),
    .speed_i  (spd2),
    .croc_y_o (bus.CrocY2)
  );

  croc_mover #(
    .YReset  (CROC_Y_MAX),
    .DirReset(DirUp),
    .YMin    (CROC_Y_MIN),
    .YMax    (CROC_Y_MAX)
  ) u_croc3 (
    .dclk     (dclk),
    .rst      (rst),
    .tick_i   (tick),
    .enable_i (croc_en),
    .restart_i(croc_restart),
    .speed_i  (spd3),
    .croc_y_o (bus.CrocY3)
  );

  assign bus.FrogX      = frog_x_q;
  assign bus.FrogY      = frog_y_q;
  assign bus.game_state = state_q;
  assign bus.lives      = lives_q;

endmodule
